m_axi_ctrl: RTL

Single-beat AXI initiator that drives the write-address, write-data, write-response, read-address and read-data channels of the register slaves on the control bus. It accepts one command at a time from a local command port (write or read, 32-bit address and data) and runs the full AXI handshake sequence. It returns the outcome on a response port. It sits between the control sequencer and the slave register blocks and is the counterpart that exercises them.

---
 rtl/m_axi_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/m_axi_ctrl.sv
// rtl/m_axi_ctrl.sv - single-beat AXI initiator for the control bus
// Optional ID check on bid_i/rid_i is enabled by defining M_AXI_ID_CHECK_EN.
module m_axi_ctrl #(
  parameter logic [3:0] ID_BASE = 4'h0,
  parameter int         ID_INCR = 1
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_wstrb_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_write_o,
  output logic [31:0] rsp_rdata_o,
  output logic [1:0]  rsp_resp_o,
  output logic [3:0]  awid_o,
  output logic [31:0] awaddr_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [3:0]  wid_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wlast_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  input  logic [3:0]  bid_i,
  input  logic [1:0]  bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o,
  output logic [3:0]  arid_o,
  output logic [31:0] araddr_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic [3:0]  rid_i,
  input  logic [31:0] rdata_i,
  input  logic [3:0]  rstrb_i,
  input  logic        rlast_i,
  input  logic        rvalid_i,
  output logic        rready_o
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  state_t     state;
  logic [3:0] id;
  logic       aw_done;
  logic       w_done;
  logic       aw_hs;
  logic       w_hs;
  logic       b_id_bad;
  logic       r_id_bad;

  assign aw_hs   = awvalid_o && awready_i;
  assign w_hs    = wvalid_o && wready_i;
  assign wlast_o = wvalid_o;

`ifdef M_AXI_ID_CHECK_EN
  logic unused_in;
  assign unused_in = ^rstrb_i;
  assign b_id_bad  = (bid_i != id);
  assign r_id_bad  = (rid_i != id);
`else
  logic unused_in;
  assign unused_in = ^{rstrb_i, bid_i, rid_i};
  assign b_id_bad  = 1'b0;
  assign r_id_bad  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (areset) begin
      state       <= IDLE;
      id          <= ID_BASE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      cmd_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_write_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_resp_o  <= '0;
      awid_o      <= '0;
      awaddr_o    <= '0;
      awvalid_o   <= 1'b0;
      wid_o       <= '0;
      wdata_o     <= '0;
      wstrb_o     <= '0;
      wvalid_o    <= 1'b0;
      bready_o    <= 1'b0;
      arid_o      <= '0;
      araddr_o    <= '0;
      arvalid_o   <= 1'b0;
      rready_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_ready_o && cmd_valid_i) begin
            cmd_ready_o <= 1'b0;
            if (cmd_write_i) begin
              awid_o    <= id;
              awaddr_o  <= cmd_addr_i;
              awvalid_o <= 1'b1;
              wid_o     <= id;
              wdata_o   <= cmd_wdata_i;
              wstrb_o   <= cmd_wstrb_i;
              wvalid_o  <= 1'b1;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
              state     <= WR_REQ;
            end else begin
              arid_o    <= id;
              araddr_o  <= cmd_addr_i;
              arvalid_o <= 1'b1;
              state     <= RD_REQ;
            end
          end else begin
            cmd_ready_o <= 1'b1;
          end
        end
        // AW and W complete independently; B is only opened once both are done.
        WR_REQ: begin
          if (aw_hs) begin
            awvalid_o <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            wvalid_o <= 1'b0;
            w_done   <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            bready_o <= 1'b1;
            state    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid_i) begin
            bready_o    <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_write_o <= 1'b1;
            rsp_rdata_o <= '0;
            rsp_resp_o  <= b_id_bad ? 2'b10 : bresp_i;
            state       <= RSP;
          end
        end
        RD_REQ: begin
          if (arready_i) begin
            arvalid_o <= 1'b0;
            rready_o  <= 1'b1;
            state     <= RD_DATA;
          end
        end
        // A single-beat read must carry rlast; a missing rlast is reported as SLVERR.
        RD_DATA: begin
          if (rvalid_i) begin
            rready_o    <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_write_o <= 1'b0;
            rsp_rdata_o <= rdata_i;
            rsp_resp_o  <= (r_id_bad || !rlast_i) ? 2'b10 : 2'b00;
            state       <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            if (ID_INCR != 0) id <= id + 4'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
